blink_gen: RTL

BLINK_GEN -- requirements
Module: blink_gen

---
 rtl/blink_gen.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/blink_gen.sv
// rtl/blink_gen.sv - multi-channel blink generator with serial-divider configuration
`timescale 1ns/1ps

module blink_gen #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int CHANNELS = 4,
    parameter int SPEED_W  = 4,
    localparam int CNT_W   = $clog2(CLK_FREQ + 1),
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [SPEED_W-1:0]  cfg_speed,
    output logic [CHANNELS-1:0] out,
    output logic                busy
);

    localparam int                ITER_W    = $clog2(CNT_W + 1);
    localparam logic [CNT_W-1:0]  DIVIDEND  = CNT_W'(CLK_FREQ);
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(CNT_W - 1);

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_PULSE  = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_COMMIT
    } state_t;

    state_t              state;
    logic [CH_W-1:0]     ch_q;
    logic [1:0]          mode_q;
    logic [SPEED_W-1:0]  spd_q;
    logic [ITER_W-1:0]   iter_q;
    logic [CNT_W-1:0]    dvd_q;
    logic [CNT_W-1:0]    quo_q;
    logic [SPEED_W-1:0]  rem_q;

    // Divider datapath: the remainder never reaches the divisor, so SPEED_W bits
    // hold it and the low bits of the difference are exact whenever we subtract.
    // A zero divisor just yields an all-ones quotient, which the commit discards.
    logic [SPEED_W:0]    rem_sh;
    logic [SPEED_W-1:0]  rem_sub;
    logic                q_bit;

    assign rem_sh  = {rem_q, dvd_q[CNT_W-1]};
    assign q_bit   = (rem_sh >= {1'b0, spd_q});
    assign rem_sub = rem_sh[SPEED_W-1:0] - spd_q;

    // Values written into the target channel on the COMMIT edge
    logic                commit_en;
    logic                commit_off;
    logic [1:0]          commit_mode;
    logic [CNT_W-1:0]    commit_tc;

    assign commit_en   = (state == ST_COMMIT);
    assign commit_off  = (spd_q == '0) || (mode_q == MODE_RSVD);
    assign commit_mode = commit_off ? MODE_OFF : mode_q;
    assign commit_tc   = commit_off ? '0 : quo_q;

    // Control FSM: capture a request, run one quotient bit per cycle, then commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
            ch_q      <= '0;
            mode_q    <= MODE_OFF;
            spd_q     <= '0;
            iter_q    <= '0;
            dvd_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cfg_ready <= 1'b1;
                    busy      <= 1'b0;
                    if (cfg_valid && cfg_ready) begin
                        ch_q      <= cfg_ch;
                        mode_q    <= cfg_mode;
                        spd_q     <= cfg_speed;
                        iter_q    <= '0;
                        dvd_q     <= DIVIDEND;
                        quo_q     <= '0;
                        rem_q     <= '0;
                        cfg_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    dvd_q  <= dvd_q << 1;
                    quo_q  <= (quo_q << 1) | CNT_W'(q_bit);
                    rem_q  <= q_bit ? rem_sub : rem_sh[SPEED_W-1:0];
                    iter_q <= iter_q + 1'b1;
                    if (iter_q == LAST_ITER) begin
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    cfg_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    cfg_ready <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    // Channel array; an out-of-range ch_q matches no index and so changes nothing
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [1:0]       mode_r;
        logic [CNT_W-1:0] tc_r;
        logic [CNT_W-1:0] cnt_r;
        logic             out_r;
        logic             hit;
        logic             at_tc;

        assign hit   = commit_en && (ch_q == CH_W'(i));
        assign at_tc = (cnt_r == tc_r);

        // Per-channel counter: commit overrides, otherwise run the current mode
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mode_r <= MODE_OFF;
                tc_r   <= '0;
                cnt_r  <= '0;
                out_r  <= 1'b0;
            end else if (hit) begin
                mode_r <= commit_mode;
                tc_r   <= commit_tc;
                cnt_r  <= '0;
                out_r  <= 1'b0;
            end else begin
                case (mode_r)
                    MODE_TOGGLE: begin
                        if (at_tc) begin
                            out_r <= ~out_r;
                            cnt_r <= '0;
                        end else begin
                            cnt_r <= cnt_r + 1'b1;
                        end
                    end
                    MODE_PULSE: begin
                        if (at_tc) begin
                            out_r <= 1'b1;
                            cnt_r <= '0;
                        end else begin
                            out_r <= 1'b0;
                            cnt_r <= cnt_r + 1'b1;
                        end
                    end
                    default: begin
                        out_r <= 1'b0;
                        cnt_r <= '0;
                    end
                endcase
            end
        end

        assign out[i] = out_r;
    end

endmodule
